// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: states, opcodes, bus source codes,
// register write-enable bit positions and ALU operation codes.
package cu_pkg;

  localparam int BUS_W = 16;

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH1,
    S_FETCH2,
    S_DECODE,
    S_LD1,
    S_LD2,
    S_LD3,
    S_ST1,
    S_ST2,
    S_ST3,
    S_CLAC,
    S_INAC,
    S_ADD,
    S_SUB,
    S_MVACR,
    S_MVRAC,
    S_J1,
    S_J2,
    S_SKIP,
    S_HALT
  } state_t;

  localparam int OP_NOP   = 0;
  localparam int OP_LDAC  = 1;
  localparam int OP_STAC  = 2;
  localparam int OP_CLAC  = 3;
  localparam int OP_INAC  = 4;
  localparam int OP_ADD   = 5;
  localparam int OP_SUB   = 6;
  localparam int OP_MVACR = 7;
  localparam int OP_MVRAC = 8;
  localparam int OP_JMP   = 9;
  localparam int OP_JMPZ  = 10;
  localparam int OP_END   = 11;

  localparam logic [3:0] BUS_NONE = 4'd0;
  localparam logic [3:0] BUS_MEM  = 4'd1;
  localparam logic [3:0] BUS_PC   = 4'd2;
  localparam logic [3:0] BUS_IR   = 4'd3;
  localparam logic [3:0] BUS_AC   = 4'd5;
  localparam logic [3:0] BUS_R    = 4'd14;

  localparam int WR_AR = 0;
  localparam int WR_PC = 1;
  localparam int WR_IR = 2;
  localparam int WR_AC = 3;
  localparam int WR_R  = 4;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/cu_decode.sv
// Moore output table: maps the sequencer state onto bus select and datapath strobes.
module cu_decode
  import cu_pkg::*;
(
  input  state_t     state,
  output logic [3:0] bus_sel,
  output logic [4:0] wr_en,
  output logic       pc_inc,
  output logic       ac_inc,
  output logic       ac_clr,
  output logic       alu_to_ac,
  output logic [2:0] alu_op,
  output logic       mem_we,
  output logic       busy,
  output logic       halted
);

  always_comb begin
    bus_sel   = BUS_NONE;
    wr_en     = '0;
    pc_inc    = 1'b0;
    ac_inc    = 1'b0;
    ac_clr    = 1'b0;
    alu_to_ac = 1'b0;
    alu_op    = ALU_PASS;
    mem_we    = 1'b0;
    busy      = (state != S_IDLE) && (state != S_HALT);
    halted    = (state == S_HALT);

    case (state)
      S_FETCH1, S_LD1, S_ST1, S_J1: begin
        bus_sel      = BUS_PC;
        wr_en[WR_AR] = 1'b1;
      end
      S_FETCH2: begin
        bus_sel      = BUS_MEM;
        wr_en[WR_IR] = 1'b1;
        pc_inc       = 1'b1;
      end
      // Second operand fetch: the address word replaces AR and PC skips past it.
      S_LD2, S_ST2: begin
        bus_sel      = BUS_MEM;
        wr_en[WR_AR] = 1'b1;
        pc_inc       = 1'b1;
      end
      S_LD3: begin
        bus_sel      = BUS_MEM;
        wr_en[WR_AC] = 1'b1;
      end
      S_ST3: begin
        bus_sel = BUS_AC;
        mem_we  = 1'b1;
      end
      S_CLAC: ac_clr = 1'b1;
      S_INAC: ac_inc = 1'b1;
      S_ADD: begin
        alu_op    = ALU_ADD;
        alu_to_ac = 1'b1;
      end
      S_SUB: begin
        alu_op    = ALU_SUB;
        alu_to_ac = 1'b1;
      end
      S_MVACR: begin
        bus_sel     = BUS_AC;
        wr_en[WR_R] = 1'b1;
      end
      S_MVRAC: begin
        bus_sel      = BUS_R;
        wr_en[WR_AC] = 1'b1;
      end
      S_J2: begin
        bus_sel      = BUS_MEM;
        wr_en[WR_PC] = 1'b1;
      end
      S_SKIP: pc_inc = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer; owns the state register and
// next-state logic, with outputs decoded from state by cu_decode.
module control_unit
  import cu_pkg::*;
#(
  parameter int N   = 16,
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  output logic [3:0]     bus_sel,
  output logic [4:0]     wr_en,
  output logic           pc_inc,
  output logic           ac_inc,
  output logic           ac_clr,
  output logic           alu_to_ac,
  output logic [2:0]     alu_op,
  output logic           mem_we,
  output logic           busy,
  output logic           halted
);

  state_t state, next_state;

  if (N != BUS_W) begin : g_width_check
    $error("control_unit: N must equal cu_pkg::BUS_W");
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start) next_state = S_FETCH1;
      S_FETCH1: next_state = S_FETCH2;
      S_FETCH2: next_state = S_DECODE;
      // Unassigned opcodes fall through to the default and behave as NOP.
      S_DECODE: begin
        case (opcode)
          OPW'(OP_LDAC):  next_state = S_LD1;
          OPW'(OP_STAC):  next_state = S_ST1;
          OPW'(OP_CLAC):  next_state = S_CLAC;
          OPW'(OP_INAC):  next_state = S_INAC;
          OPW'(OP_ADD):   next_state = S_ADD;
          OPW'(OP_SUB):   next_state = S_SUB;
          OPW'(OP_MVACR): next_state = S_MVACR;
          OPW'(OP_MVRAC): next_state = S_MVRAC;
          OPW'(OP_JMP):   next_state = S_J1;
          OPW'(OP_JMPZ):  next_state = z_flag ? S_J1 : S_SKIP;
          OPW'(OP_END):   next_state = S_HALT;
          default:        next_state = S_FETCH1;
        endcase
      end
      S_LD1:   next_state = S_LD2;
      S_LD2:   next_state = S_LD3;
      S_ST1:   next_state = S_ST2;
      S_ST2:   next_state = S_ST3;
      S_J1:    next_state = S_J2;
      S_LD3, S_ST3, S_CLAC, S_INAC, S_ADD, S_SUB,
      S_MVACR, S_MVRAC, S_J2, S_SKIP:
               next_state = S_FETCH1;
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  cu_decode u_decode (
    .state     (state),
    .bus_sel   (bus_sel),
    .wr_en     (wr_en),
    .pc_inc    (pc_inc),
    .ac_inc    (ac_inc),
    .ac_clr    (ac_clr),
    .alu_to_ac (alu_to_ac),
    .alu_op    (alu_op),
    .mem_we    (mem_we),
    .busy      (busy),
    .halted    (halted)
  );

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: random instruction streams compared
// cycle by cycle against a per-opcode table of expected strobe sequences.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] opcode;
  logic       z_flag;
  logic [3:0] bus_sel;
  logic [4:0] wr_en;
  logic       pc_inc;
  logic       ac_inc;
  logic       ac_clr;
  logic       alu_to_ac;
  logic [2:0] alu_op;
  logic       mem_we;
  logic       busy;
  logic       halted;

  typedef struct packed {
    logic [3:0] bus;
    logic [4:0] wr;
    logic       pcInc;
    logic       acInc;
    logic       acClr;
    logic       aluToAc;
    logic [2:0] aluOp;
    logic       memWe;
    logic       busy;
    logic       halted;
  } ctrl_t;

  ctrl_t expq[$];
  ctrl_t idleExp;
  ctrl_t haltExp;
  int    compareCount = 0;
  int    failCount    = 0;

  control_unit #(.N(16), .OPW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .opcode    (opcode),
    .z_flag    (z_flag),
    .bus_sel   (bus_sel),
    .wr_en     (wr_en),
    .pc_inc    (pc_inc),
    .ac_inc    (ac_inc),
    .ac_clr    (ac_clr),
    .alu_to_ac (alu_to_ac),
    .alu_op    (alu_op),
    .mem_we    (mem_we),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // One busy cycle: bus source, register load mask and the single-bit strobes.
  function automatic ctrl_t mk(input int bus, input int wr, input bit pci, input bit aci,
                               input bit acc, input bit a2a, input int aop, input bit mwe);
    ctrl_t c;
    c         = '0;
    c.bus     = bus[3:0];
    c.wr      = wr[4:0];
    c.pcInc   = pci;
    c.acInc   = aci;
    c.acClr   = acc;
    c.aluToAc = a2a;
    c.aluOp   = aop[2:0];
    c.memWe   = mwe;
    c.busy    = 1'b1;
    return c;
  endfunction

  // Expected cycle sequence from entering FETCH1 until the next FETCH1 (or HALT).
  function automatic void buildSeq(input int op, input bit z);
    expq.delete();
    expq.push_back(mk(2, 5'b00001, 0, 0, 0, 0, 0, 0));
    expq.push_back(mk(1, 5'b00100, 1, 0, 0, 0, 0, 0));
    expq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    case (op)
      1: begin
        expq.push_back(mk(2, 5'b00001, 0, 0, 0, 0, 0, 0));
        expq.push_back(mk(1, 5'b00001, 1, 0, 0, 0, 0, 0));
        expq.push_back(mk(1, 5'b01000, 0, 0, 0, 0, 0, 0));
      end
      2: begin
        expq.push_back(mk(2, 5'b00001, 0, 0, 0, 0, 0, 0));
        expq.push_back(mk(1, 5'b00001, 1, 0, 0, 0, 0, 0));
        expq.push_back(mk(5, 0, 0, 0, 0, 0, 0, 1));
      end
      3:  expq.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0));
      4:  expq.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
      5:  expq.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
      6:  expq.push_back(mk(0, 0, 0, 0, 0, 1, 2, 0));
      7:  expq.push_back(mk(5, 5'b10000, 0, 0, 0, 0, 0, 0));
      8:  expq.push_back(mk(14, 5'b01000, 0, 0, 0, 0, 0, 0));
      9, 10: begin
        if (op == 9 || z) begin
          expq.push_back(mk(2, 5'b00001, 0, 0, 0, 0, 0, 0));
          expq.push_back(mk(1, 5'b00010, 0, 0, 0, 0, 0, 0));
        end else begin
          expq.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
        end
      end
      default: ;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input ctrl_t expv, input string tag);
    ctrl_t obs;
    obs = {bus_sel, wr_en, pc_inc, ac_inc, ac_clr, alu_to_ac, alu_op, mem_we, busy, halted};
    compareCount++;
    assert (obs === expv)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, expv);
    end
  endtask

  // Runs one instruction starting in FETCH1; start is toggled randomly and must be ignored.
  task automatic applyStimulus(input int op, input bit z);
    buildSeq(op, z);
    opcode = 8'(op);
    z_flag = z;
    for (int k = 0; k < expq.size(); k++) begin
      checkOutput(expq[k], $sformatf("op%0d_z%0d_c%0d", op, z, k));
      start = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  initial begin
    int op;
    bit z;
    idleExp       = '0;
    haltExp       = '0;
    haltExp.halted = 1'b1;

    rst    = 1'b1;
    start  = 1'b1;
    opcode = '0;
    z_flag = 1'b0;
    tick();
    tick();
    checkOutput(idleExp, "reset");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput(idleExp, "idle_hold");
    start = 1'b1;
    tick();
    start = 1'b0;

    applyStimulus(1, 1'b0);
    applyStimulus(5, 1'b0);
    applyStimulus(6, 1'b1);
    applyStimulus(10, 1'b1);
    applyStimulus(10, 1'b0);
    applyStimulus(9, 1'b0);
    applyStimulus(2, 1'b0);
    applyStimulus(0, 1'b1);
    applyStimulus(15, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 15));
      if (op == 11) op = 12;
      z = 1'($urandom_range(0, 1));
      applyStimulus(op, z);
    end

    // Abort an LDAC in LD2: the following cycle must be a clean IDLE.
    buildSeq(1, 1'b0);
    opcode = 8'd1;
    for (int k = 0; k < 4; k++) begin
      checkOutput(expq[k], $sformatf("abort_c%0d", k));
      tick();
    end
    checkOutput(expq[4], "abort_ld2");
    rst   = 1'b1;
    start = 1'b1;
    tick();
    checkOutput(idleExp, "abort_idle");
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput(idleExp, "abort_idle_hold");
    start = 1'b1;
    tick();
    start = 1'b0;

    applyStimulus(4, 1'b0);
    applyStimulus(11, 1'b0);
    for (int k = 0; k < 6; k++) begin
      start = 1'b1;
      checkOutput(haltExp, $sformatf("halt_c%0d", k));
      tick();
    end
    rst = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    checkOutput(idleExp, "halt_reset");
    tick();
    checkOutput(idleExp, "halt_reset_hold");

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle fetch/decode/execute sequencer. It is the initiator that drives the accumulator's write_en, inc_en, clr_en and alu_to_ac strobes, plus the other register write enables.
- Owns the shared-bus source select: exactly one source drives the bus each cycle.
- Sits between the instruction register/ALU flags and the datapath registers (AR, PC, IR, AC, R) and the data memory.

Parameters:
- N, 16, bus width; only carried through to the shared package width constant, not used internally.
- OPW, 8, opcode width taken from the IR low bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  leave IDLE and begin fetching.
- opcode  in  OPW  IR[OPW-1:0], valid from the DECODE cycle on.
- z_flag  in  1  ALU zero flag (AC == 0).
- bus_sel  out  4  bus source: 0 none, 1 MEM, 2 PC, 3 IR, 5 AC, 14 R.
- wr_en  out  5  one-hot register load from bus: bit0 AR, bit1 PC, bit2 IR, bit3 AC, bit4 R.
- pc_inc  out  1  PC increment.
- ac_inc  out  1  AC increment (drives the accumulator's inc_en).
- ac_clr  out  1  AC clear (drives clr_en).
- alu_to_ac  out  1  load ALU result into AC.
- alu_op  out  3  0 pass, 1 add (AC+R), 2 sub (AC-R).
- mem_we  out  1  memory write at address AR with bus data.
- busy  out  1  high in every state except IDLE and HALT.
- halted  out  1  high in HALT.

Behaviour:
- Only the state register is clocked. All outputs are Moore, decoded from state; unlisted outputs are 0 in each state.
- Reset: state=IDLE. All strobes 0, bus_sel=0, busy=0, halted=0. rst wins over every other input and aborts any instruction mid-flight with no partial strobes on the following cycle.
- Memory read is asynchronous from AR: MEM data is on the bus in the cycle after AR is loaded.
- IDLE: stay while start=0; on start=1 go to FETCH1.
- FETCH1: bus=PC, wr AR. Next: FETCH2.
- FETCH2: bus=MEM, wr IR, pc_inc. Next: DECODE.
- DECODE: no strobes; branch on opcode:
  - 0 NOP: go to FETCH1.
  - 1 LDAC: LD1 (bus=PC, wr AR) -> LD2 (bus=MEM, wr AR, pc_inc) -> LD3 (bus=MEM, wr AC) -> FETCH1.
  - 2 STAC: ST1 (bus=PC, wr AR) -> ST2 (bus=MEM, wr AR, pc_inc) -> ST3 (bus=AC, mem_we) -> FETCH1.
  - 3 CLAC: EX (ac_clr) -> FETCH1.
  - 4 INAC: EX (ac_inc) -> FETCH1.
  - 5 ADD: EX (alu_op=1, alu_to_ac) -> FETCH1.
  - 6 SUB: EX (alu_op=2, alu_to_ac) -> FETCH1.
  - 7 MVACR: EX (bus=AC, wr R) -> FETCH1.
  - 8 MVRAC: EX (bus=R, wr AC) -> FETCH1.
  - 9 JMP: J1 (bus=PC, wr AR) -> J2 (bus=MEM, wr PC) -> FETCH1.
  - 10 JMPZ: if z_flag (sampled in DECODE) take J1/J2; otherwise SKIP (pc_inc) -> FETCH1.
  - 11 END: go to HALT.
  - Any other opcode: treated as NOP.
- HALT: halted=1; sticky until rst. start is ignored.
- start is ignored outside IDLE.
- Invariants: wr_en is at most one-hot; ac_inc, ac_clr, alu_to_ac and AC write are never asserted together.
- Cycle counts (IDLE exit to next FETCH1): NOP 3; 1-cycle ops 4; LDAC/STAC 6; JMP 5; JMPZ not-taken 4.

Decomposition:
- Shared package cu_pkg holds:
  - state enum;
  - opcode constants (NOP..END);
  - bus_sel codes (BUS_MEM=1, BUS_PC=2, BUS_IR=3, BUS_AC=5, BUS_R=14);
  - wr_en bit indices;
  - ALU op codes.
- One natural sub-module, cu_decode: purely combinational state-to-strobe table.
- Next-state logic and the state register stay in control_unit.

Test Plan:
- Reset then start=1 pulse -> FETCH1 next cycle: bus_sel=2, wr_en=5'b00001. FETCH2: bus_sel=1, wr_en=5'b00100, pc_inc=1.
- opcode=1 (LDAC) -> LD1/LD2/LD3 strobes in order. LD3: bus_sel=1, wr_en=5'b01000. FETCH1 reached exactly 6 cycles after IDLE exit.
- opcode=5 then opcode=6 -> single EX cycle each: alu_to_ac=1 with alu_op=1 and alu_op=2 respectively. No wr_en bit set.
- opcode=10 with z_flag=1 -> J2 asserts wr_en=5'b00010. With z_flag=0 -> SKIP asserts pc_inc=1 and no wr_en.
- opcode=11 -> halted=1 and busy=0 indefinitely. start=1 has no effect; rst=1 returns to IDLE next cycle.
- rst asserted in LD2 -> next cycle all strobes 0, state IDLE. A new start re-fetches from FETCH1.
